// File: rtl/keypad_entry_scanner.sv
// 4x4 matrix keypad scanner: column drive, frame-based debounce, decimal 0-255 entry.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry_scanner #(
    parameter int SCAN_DIV_W      = 17,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] entry,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       err
);
    localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_FRAMES);
    // A misconfigured instance never evaluates a frame, so it stays silent.
    localparam bit CFG_OK = (SCAN_DIV_W >= 2) && (DEBOUNCE_FRAMES >= 1) &&
                            (DEBOUNCE_FRAMES <= 15) && (REPEAT_FRAMES >= 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD} state_t;

    logic [3:0]            row_sync1_reg, row_sync2_reg;
    logic [SCAN_DIV_W-1:0] dwell_reg;
    logic [1:0]            col_reg;
    logic                  tick, frame_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sync1_reg <= 4'hF;
            row_sync2_reg <= 4'hF;
            dwell_reg     <= '0;
            col_reg       <= 2'd0;
        end else begin
            row_sync1_reg <= row_n;
            row_sync2_reg <= row_sync1_reg;
            dwell_reg     <= dwell_reg + SCAN_DIV_W'(1);
            if (tick) col_reg <= col_reg + 2'd1;
        end
    end

    assign tick       = &dwell_reg;
    assign frame_tick = tick && (col_reg == 2'd3) && CFG_OK;
    assign col_n      = ~(4'b0001 << col_reg);

    // Per-frame switch count saturates at 2, which already means "ghost".
    logic [3:0] col_hits;
    logic [2:0] col_pop;
    logic [1:0] col_row;
    logic [2:0] hit_sum;
    logic [1:0] hit_total;
    logic [1:0] hit_cnt_reg;
    logic [3:0] hit_code_reg;
    logic [3:0] frame_code;
    logic       frame_single;

    always_comb begin
        col_hits = ~row_sync2_reg;
        col_pop  = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (col_hits[r]) begin
                col_pop = col_pop + 3'd1;
                col_row = 2'(r);
            end
        end
        hit_sum      = {1'b0, hit_cnt_reg} + col_pop;
        hit_total    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code   = (hit_cnt_reg == 2'd1) ? hit_code_reg : {col_row, col_reg};
        frame_single = frame_tick && (hit_total == 2'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_reg  <= 2'd0;
            hit_code_reg <= 4'd0;
        end else if (tick) begin
            hit_cnt_reg  <= (col_reg == 2'd3) ? 2'd0 : hit_total;
            hit_code_reg <= frame_code;
        end
    end

    state_t     state_reg, state_next;
    logic [3:0] cand_reg, cand_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] rcnt_reg, rcnt_next;
    logic       accept, rpt_fire, key_fire;
    logic       key_valid_reg;
    logic [3:0] key_code_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cand_reg      <= 4'd0;
            cnt_reg       <= 4'd0;
            rcnt_reg      <= 4'd0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'd0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            rcnt_reg      <= rcnt_next;
            key_valid_reg <= key_fire;
            if (key_fire) key_code_reg <= cand_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        rcnt_next  = rcnt_reg;
        if (frame_tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (frame_single) begin
                        cand_next  = frame_code;
                        cnt_next   = 4'd1;
                        rcnt_next  = 4'd0;
                        state_next = (DB_LIM == 4'd1) ? ST_HELD : ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (!frame_single) begin
                        state_next = ST_IDLE;
                    end else if (frame_code == cand_reg) begin
                        cnt_next = cnt_reg + 4'd1;
                        if (cnt_next == DB_LIM) begin
                            state_next = ST_HELD;
                            rcnt_next  = 4'd0;
                        end
                    end else begin
                        cand_next = frame_code;
                        cnt_next  = 4'd1;
                    end
                end
                ST_HELD: begin
                    if (frame_single) begin
                        rcnt_next = 4'd0;
                    end else begin
                        rcnt_next = rcnt_reg + 4'd1;
                        if (rcnt_next == DB_LIM) state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A key is accepted exactly when the debouncer enters HELD.
    always_comb begin
        accept   = (state_reg != ST_HELD) && (state_next == ST_HELD);
        key_fire = accept || rpt_fire;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_LIM = RPT_W'(REPEAT_FRAMES);
    logic [RPT_W-1:0] rpt_reg, rpt_next;

    always_comb begin
        rpt_next = rpt_reg;
        rpt_fire = 1'b0;
        if (state_reg != ST_HELD) begin
            rpt_next = '0;
        end else if (frame_tick) begin
            if (frame_single && (frame_code == cand_reg)) begin
                if (rpt_reg + RPT_W'(1) == RPT_LIM) begin
                    rpt_fire = 1'b1;
                    rpt_next = '0;
                end else begin
                    rpt_next = rpt_reg + RPT_W'(1);
                end
            end else begin
                rpt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rpt_reg <= '0;
        else          rpt_reg <= rpt_next;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    logic [7:0]  entry_reg, value_reg;
    logic        value_valid_reg, err_reg;
    logic [11:0] digit_sum;

    assign digit_sum = 12'(entry_reg) * 12'd10 + 12'(key_code_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_reg       <= 8'd0;
            value_reg       <= 8'd0;
            value_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            value_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            if (key_valid_reg) begin
                case (key_code_reg)
                    4'hA: begin
                        value_reg       <= entry_reg;
                        value_valid_reg <= 1'b1;
                        entry_reg       <= 8'd0;
                    end
                    4'hB: entry_reg <= entry_reg / 8'd10;
                    4'hC: entry_reg <= 8'd0;
                    4'hD, 4'hE, 4'hF: ;
                    default: begin
                        if (digit_sum <= 12'd255) entry_reg <= digit_sum[7:0];
                        else                      err_reg   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign entry       = entry_reg;
    assign value       = value_reg;
    assign value_valid = value_valid_reg;
    assign err         = err_reg;
endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Bench for keypad_entry_scanner: emulated keypad, frame-level behavioural model, per-cycle compare.
`timescale 1ns/1ps
module tb_keypad_entry_scanner;
    localparam int DF = 2;
    localparam int RF = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] entry;
    logic [7:0] value;
    logic       value_valid;
    logic       err;

    keypad_entry_scanner #(
        .SCAN_DIV_W(2),
        .DEBOUNCE_FRAMES(DF),
        .REPEAT_FRAMES(RF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .row_n(row_n),
        .col_n(col_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .entry(entry),
        .value(value),
        .value_valid(value_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held switch pulls its row low while its column is driven.
    logic [15:0] keys_down = 16'h0;
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    int n_checks = 0;
    int n_fail = 0;
    int kv_pulses = 0;
    int err_pulses = 0;
    int vv_pulses = 0;
    bit checking = 1'b0;

    // Model state: time in clocks since reset release, frame masks, debounce run lengths.
    int          k;
    logic [15:0] cur_mask, next_mask;
    logic [3:0]  exp_col;
    int          exp_kv, exp_code, exp_vv, exp_err;
    int          entry_m, value_m;
    bit          armed;
    int          run, last_key, nrun, held_key, rpt;
    bit          pending;
    int          pending_code;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_col  = 4'b1110;
        exp_kv   = 0;
        exp_code = 0;
        exp_vv   = 0;
        exp_err  = 0;
        entry_m  = 0;
        value_m  = 0;
        armed    = 1'b1;
        run      = 0;
        last_key = 0;
        nrun     = 0;
        held_key = 0;
        rpt      = 0;
        pending  = 1'b0;
        k        = 0;
    endtask

    task automatic accept_key(input int key);
        exp_kv       = 1;
        exp_code     = key;
        pending      = 1'b1;
        pending_code = key;
    endtask

    task automatic eval_frame(input logic [15:0] mask);
        int cnt;
        int key;
        cnt = 0;
        key = 0;
        for (int b = 0; b < 16; b++)
            if (mask[b]) begin
                cnt++;
                key = b;
            end
        if (cnt == 1) begin
            if (armed) begin
                run      = (run > 0 && key == last_key) ? run + 1 : 1;
                last_key = key;
                if (run == DF) begin
                    accept_key(key);
                    armed    = 1'b0;
                    nrun     = 0;
                    rpt      = 0;
                    held_key = key;
                end
            end else begin
                nrun = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                if (key == held_key) begin
                    rpt++;
                    if (rpt == RF) begin
                        rpt = 0;
                        accept_key(key);
                    end
                end else begin
                    rpt = 0;
                end
`endif
            end
        end else begin
            run = 0;
            if (!armed) begin
                nrun++;
                rpt = 0;
                if (nrun == DF) armed = 1'b1;
            end
        end
    endtask

    task automatic apply_action(input int code);
        case (code)
            10: begin
                value_m = entry_m;
                exp_vv  = 1;
                entry_m = 0;
            end
            11: entry_m = entry_m / 10;
            12: entry_m = 0;
            13, 14, 15: ;
            default: begin
                if (entry_m * 10 + code <= 255) entry_m = entry_m * 10 + code;
                else exp_err = 1;
            end
        endcase
    endtask

    // Called at the falling edge that opens clock state k (k rising edges since release).
    task automatic step();
        int i;
        i = k % 16;
        exp_col = ~(4'b0001 << (i / 4));
        exp_kv  = 0;
        exp_vv  = 0;
        exp_err = 0;
        if (i == 1 && pending) begin
            apply_action(pending_code);
            pending = 1'b0;
        end
        if (i == 0) begin
            if (k > 0) eval_frame(cur_mask);
            cur_mask  = next_mask;
            keys_down = next_mask;
        end
        k++;
    endtask

    task automatic run_states(input logic [15:0] mask, input int n);
        next_mask = mask;
        repeat (n) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n);
        run_states(mask, n * 16);
    endtask

    task automatic press(input int code);
        run_frames(16'(1) << code, DF);
        run_frames(16'h0, DF);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Compare process: every cycle, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (checking) begin
                chk("col_n", col_n, exp_col);
                chk("key_valid", key_valid, exp_kv);
                chk("key_code", key_code, exp_code);
                chk("entry", entry, entry_m);
                chk("value", value, value_m);
                chk("value_valid", value_valid, exp_vv);
                chk("err", err, exp_err);
                if (key_valid) kv_pulses++;
                if (err) err_pulses++;
                if (value_valid) vv_pulses++;
            end
        end
    end

    initial begin
        int kv_before;
        model_reset();
        cur_mask  = 16'h0;
        next_mask = 16'h0;
        checking  = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_col_lit", col_n, 4'b1110);
        chk("rst_entry_lit", entry, 0);
        chk("rst_value_lit", value, 0);
        $display("reset released, idle scan");
        run_frames(16'h0, 2);
        chk("idle_pulses_lit", kv_pulses, 0);

        // Row 1 low while column 2 driven: key 6, held 3 frames then released.
        run_frames(16'h0040, 3);
        run_frames(16'h0, 2);
        $display("key 6 held: key_code=%0d entry=%0d", key_code, entry);
        chk("k6_pulses_lit", kv_pulses, 1);
        chk("k6_code_lit", key_code, 6);
        chk("k6_entry_lit", entry, 6);

        press(12);
        chk("clear_lit", entry, 0);
        press(2);
        chk("seq2_lit", entry, 2);
        press(5);
        chk("seq25_lit", entry, 25);
        press(5);
        chk("seq255_lit", entry, 255);
        press(10);
        $display("enter: value=%0d entry=%0d", value, entry);
        chk("enter_value_lit", value, 255);
        chk("enter_entry_lit", entry, 0);
        chk("enter_vv_lit", vv_pulses, 1);

        press(2);
        press(5);
        press(6);
        $display("overflow digit: entry=%0d err_pulses=%0d", entry, err_pulses);
        chk("ovf_err_lit", err_pulses, 1);
        chk("ovf_entry_lit", entry, 25);
        press(11);
        chk("bksp_lit", entry, 2);
        press(12);
        chk("clr2_lit", entry, 0);
        chk("clr2_value_lit", value, 255);
        chk("press_total_lit", kv_pulses, 11);

        // Bounce then ghosts (two columns, and two rows in one column).
        kv_before = kv_pulses;
        repeat (4) begin
            run_frames(16'h0008, 1);
            run_frames(16'h0, 1);
        end
        run_frames(16'h0021, 4);
        run_frames(16'h0, 2);
        run_frames(16'h0022, 4);
        run_frames(16'h0, 2);
        $display("bounce/ghost: pulses=%0d", kv_pulses);
        chk("bounce_ghost_lit", kv_pulses, kv_before);

        // Reset while HELD with entry 25, key D still held afterwards.
        press(2);
        press(5);
        run_frames(16'h2000, 3);
        run_states(16'h2000, 5);
        chk("held_entry_lit", entry, 25);
        do_reset();
        $display("mid-run reset: entry=%0d value=%0d col_n=%b", entry, value, col_n);
        chk("mid_rst_entry_lit", entry, 0);
        chk("mid_rst_value_lit", value, 0);
        chk("mid_rst_code_lit", key_code, 0);
        kv_before = kv_pulses;
        run_frames(16'h2000, 3);
        run_frames(16'h0, 2);
        chk("reheld_pulses_lit", kv_pulses, kv_before + 1);
        chk("reheld_code_lit", key_code, 13);

        // Long hold of key 1.
        kv_before = kv_pulses;
        run_frames(16'h0002, 8);
        run_frames(16'h0, 2);
        $display("long hold key 1: entry=%0d pulses=%0d", entry, kv_pulses - kv_before);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("hold_pulses_lit", kv_pulses, kv_before + 3);
        chk("hold_entry_lit", entry, 111);
`else
        chk("hold_pulses_lit", kv_pulses, kv_before + 1);
        chk("hold_entry_lit", entry, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
